// File: rtl/signed_acc_ctrl_pkg.sv
// Shared types and the accumulate arithmetic for the signed accumulator front end.
package signed_acc_ctrl_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_CLR} op_e;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  // Returns {overflow, result}. The sum is taken one bit wider than the data,
  // so signed overflow is exactly "top two bits of the wide result differ".
  // That also covers subtracting -8: acc - (-8) = acc + 8 overflows iff acc >= 0.
  // OP_CLR and OP_NONE yield zero with overflow cleared.
  function automatic logic [DATA_W:0] acc_apply(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] opnd,
                                                input op_e               op);
    logic [DATA_W:0] a_ext;
    logic [DATA_W:0] b_ext;
    logic [DATA_W:0] r_ext;
    logic            ovf;
    a_ext = {acc[DATA_W-1], acc};
    b_ext = {opnd[DATA_W-1], opnd};
    r_ext = '0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        r_ext = a_ext + b_ext;
        ovf   = r_ext[DATA_W] ^ r_ext[DATA_W-1];
      end
      OP_SUB: begin
        r_ext = a_ext - b_ext;
        ovf   = r_ext[DATA_W] ^ r_ext[DATA_W-1];
      end
      default: begin
        r_ext = '0;
        ovf   = 1'b0;
      end
    endcase
    return {ovf, r_ext[DATA_W-1:0]};
  endfunction

endpackage

// File: rtl/signed_acc_ctrl_if.sv
// Operand, push keys and accumulator status bundled between the panel and the controller.
interface signed_acc_ctrl_if;
  import signed_acc_ctrl_pkg::*;

  logic [DATA_W-1:0] operand;
  logic              key_add_n;
  logic              key_sub_n;
  logic              key_clr_n;
  logic [DATA_W-1:0] acc_value;
  logic              overflow;
  logic              sign_led;
  logic              op_done;

  modport slave (
    input  operand, key_add_n, key_sub_n, key_clr_n,
    output acc_value, overflow, sign_led, op_done
  );

  modport master (
    output operand, key_add_n, key_sub_n, key_clr_n,
    input  acc_value, overflow, sign_led, op_done
  );

endinterface

// File: rtl/signed_acc_ctrl_key_debounce.sv
// Per-key conditioning: 2-flop synchronizer, stability counter, accepted level, press pulse.
// The synchronizer carries the raw active-low key, so its released value is 1;
// the inversion happens right after it, before comparison with the accepted level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             pressed;

  // Count consecutive cycles of disagreement; accept the new level after DEBOUNCE_CYCLES.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    cnt_d   = cnt_q + CNT_W'(1);
    level_d = level_q;
    press_d = 1'b0;
    pressed = ~sync2_q;
    if (pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = ~level_q;
      press_d = ~level_q;
    end
  end

  // Register stage with synchronous reset to the released state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/signed_acc_ctrl.sv
// Key-driven signed 4-bit accumulator feeding the seven-segment decoder.
//
//   state | meaning
//   IDLE  | waiting for a debounced press; latches opcode (clr > sub > add)
//   EXEC  | one cycle: apply latched op to acc_value/overflow, pulse op_done
//   HOLD  | waiting for every key to be released; new presses are dropped
module signed_acc_ctrl
  import signed_acc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  signed_acc_ctrl_if.slave   bus
);

  logic lvl_add, lvl_sub, lvl_clr;
  logic prs_add, prs_sub, prs_clr;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_add (
    .clk(clk), .reset(reset), .key_n(bus.key_add_n), .level(lvl_add), .press(prs_add)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sub (
    .clk(clk), .reset(reset), .key_n(bus.key_sub_n), .level(lvl_sub), .press(prs_sub)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clr (
    .clk(clk), .reset(reset), .key_n(bus.key_clr_n), .level(lvl_clr), .press(prs_clr)
  );

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  // Next-state and datapath update; the accumulator only changes in EXEC.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (prs_clr) begin
          op_d    = OP_CLR;
          state_d = EXEC;
        end else if (prs_sub) begin
          op_d    = OP_SUB;
          state_d = EXEC;
        end else if (prs_add) begin
          op_d    = OP_ADD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        {ovf_d, acc_d} = acc_apply(acc_q, bus.operand, op_q);
        done_d         = 1'b1;
        state_d        = HOLD;
      end
      HOLD: begin
        if (!(lvl_add || lvl_sub || lvl_clr)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.acc_value = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.sign_led  = acc_q[DATA_W-1];
  assign bus.op_done   = done_q;

endmodule
